// File: rtl/vga_pkg.sv
// Shared VGA/game constants: map geometry, pixel codes and cell-address layout.
package vga_pkg;
  localparam int MAP_W_DEF = 500;
  localparam int MAP_H_DEF = 192;

  localparam logic [3:0] PIX_WALL = 4'h0;
  localparam logic [3:0] PIX_DOOR = 4'h4;

  localparam int X_W   = 9;
  localparam int Y_W   = 7;
  localparam int ADR_W = X_W + Y_W;

  // A cell address is out of the map when either field exceeds the map extent.
  function automatic logic cell_oob(input logic [ADR_W-1:0] a, input int w, input int h);
    return (32'(a[X_W-1:0]) >= w) || (32'(a[ADR_W-1:X_W]) >= h);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on adv.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] r_ptr;
  logic          w_found;
  logic [IW-1:0] w_k;
  int            w_s;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_k     = '0;
    w_s     = 0;
    for (int i = 0; i < N; i++) begin
      w_s = int'(r_ptr) + i;
      if (w_s >= N) w_s = w_s - N;
      w_k = IW'(w_s);
      if (!w_found && req[w_k]) begin
        w_found  = 1'b1;
        gnt[w_k] = 1'b1;
        idx      = w_k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      r_ptr <= '0;
    else if (adv) r_ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
  end
endmodule

// File: rtl/collision_map_arbiter.sv
// Shares the collision-map ROM between requesters; fixed-latency tagged return pipeline.
module collision_map_arbiter
  import vga_pkg::*;
#(
  parameter int         N_REQ     = 3,
  parameter int         ROM_LAT   = 1,
  parameter int         MAP_W     = MAP_W_DEF,
  parameter int         MAP_H     = MAP_H_DEF,
  parameter logic [3:0] OOB_PIXEL = PIX_WALL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][ADR_W-1:0]  addr,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             rvalid,
  output logic [3:0]                   rdata,
  output logic [ADR_W-1:0]             rom_adr,
  input  logic [3:0]                   rom_data
);
  localparam int TW = $clog2(N_REQ);

  logic [N_REQ-1:0] w_gnt;
  logic [TW-1:0]    w_idx;
  logic             w_adv;
  logic             w_oob;

  logic [ROM_LAT-1:0]         r_vld_pipe;
  logic [ROM_LAT-1:0]         r_oob_pipe;
  logic [ROM_LAT-1:0][TW-1:0] r_tag_pipe;
  logic [ADR_W-1:0]           r_rom_adr;
  logic [N_REQ-1:0]           r_rvalid;
  logic [3:0]                 r_rdata;

  rr_arbiter #(.N(N_REQ), .IW(TW)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (w_adv),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_adv = |w_gnt;
  assign w_oob = cell_oob(addr[w_idx], MAP_W, MAP_H);

  // OOB accesses still go to the ROM so every return lands at the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_adr  <= '0;
      r_vld_pipe <= '0;
      r_oob_pipe <= '0;
      r_tag_pipe <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_adv) r_rom_adr <= addr[w_idx];
      for (int i = ROM_LAT-1; i > 0; i--) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_oob_pipe[i] <= r_oob_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      r_vld_pipe[0] <= w_adv;
      r_oob_pipe[0] <= w_oob;
      r_tag_pipe[0] <= w_idx;
      if (r_vld_pipe[ROM_LAT-1]) begin
        r_rdata  <= r_oob_pipe[ROM_LAT-1] ? OOB_PIXEL : rom_data;
        r_rvalid <= N_REQ'(1) << r_tag_pipe[ROM_LAT-1];
      end else begin
        r_rvalid <= '0;
      end
    end
  end

  assign gnt     = w_gnt;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rom_adr = r_rom_adr;
endmodule

// File: tb/tb_collision_map_arbiter.sv
// Directed bench: two instances (ROM_LAT=1 and ROM_LAT=3) on shared stimulus.
module tb_collision_map_arbiter;
  import vga_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [2:0][15:0] addr;

  logic [2:0]  gnt1, rvalid1, gnt3, rvalid3;
  logic [3:0]  rdata1, rdata3, rom_data1, rom_data3;
  logic [15:0] rom_adr1, rom_adr3, d1, d2;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] ba [4];
  logic [3:0]  be [4];

  always #5 clk = ~clk;

  collision_map_arbiter #(.N_REQ(3), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt1), .rvalid(rvalid1),
    .rdata(rdata1), .rom_adr(rom_adr1), .rom_data(rom_data1)
  );

  collision_map_arbiter #(.N_REQ(3), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt3), .rvalid(rvalid3),
    .rdata(rdata3), .rom_adr(rom_adr3), .rom_data(rom_data3)
  );

  function automatic logic [3:0] rom_f(input logic [15:0] a);
    case (a)
      16'h0A05: return 4'h7;
      16'h01F4: return 4'hF;
      16'h01F3: return PIX_DOOR;
      16'hFE00: return 4'h5;
      default:  return a[3:0];
    endcase
  endfunction

  // ROM model: data visible ROM_LAT cycles after rom_adr is registered.
  assign rom_data1 = rom_f(rom_adr1);
  always_ff @(posedge clk) begin
    d1 <= rom_adr3;
    d2 <= d1;
  end
  assign rom_data3 = rom_f(d2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int r);
    for (int c = 0; c < 6; c++) begin
      tick();
      req = (c < 4) ? 3'(1 << r) : 3'b000;
      if (c < 4) addr[r] = ba[c];
      #1;
      chk("burst_gnt", 32'(gnt1), (c < 4) ? (1 << r) : 0);
      chk("burst_rvalid", 32'(rvalid1), (c >= 2) ? (1 << r) : 0);
      if (c >= 2) chk("burst_rdata", 32'(rdata1), 32'(be[c-2]));
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    tick();
    tick();
    #1;
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_rvalid", 32'(rvalid1), 0);
    chk("rst_rdata", 32'(rdata1), 0);
    chk("rst_rom_adr", 32'(rom_adr1), 0);
    chk("rst_rvalid3", 32'(rvalid3), 0);
    chk("rst_rom_adr3", 32'(rom_adr3), 0);
    rst = 1'b0;

    // single request, LAT=1
    tick();
    req = 3'b001; addr[0] = 16'h0A05;
    #1 chk("t1_gnt", 32'(gnt1), 1);
    tick();
    req = 3'b000;
    #1;
    chk("t1_rom_adr", 32'(rom_adr1), 32'h0A05);
    chk("t1_rvalid_early", 32'(rvalid1), 0);
    tick();
    #1;
    chk("t1_rvalid", 32'(rvalid1), 1);
    chk("t1_rdata", 32'(rdata1), 7);

    // all three continuously from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr[0] = 16'h0011; addr[1] = 16'h0022; addr[2] = 16'h0033;
    for (int c = 0; c < 8; c++) begin
      tick();
      req = (c < 6) ? 3'b111 : 3'b000;
      #1;
      chk("t2_gnt", 32'(gnt1), (c < 6) ? (1 << (c % 3)) : 0);
      chk("t2_rvalid", 32'(rvalid1), (c >= 2) ? (1 << ((c-2) % 3)) : 0);
      if (c >= 2) chk("t2_rdata", 32'(rdata1), ((c-2) % 3) + 1);
    end

    // back-to-back from requester 1
    ba[0] = 16'h0104; ba[1] = 16'h0105; ba[2] = 16'h0106; ba[3] = 16'h0108;
    be[0] = 4'h4;     be[1] = 4'h5;     be[2] = 4'h6;     be[3] = 4'h8;
    burst(1);

    // out-of-map: x=500 wall, x=499 rom, y=127 rom, x=511 wall
    ba[0] = 16'h01F4; ba[1] = 16'h01F3; ba[2] = 16'hFE00; ba[3] = 16'hFFFF;
    be[0] = PIX_WALL; be[1] = PIX_DOOR; be[2] = 4'h5;     be[3] = PIX_WALL;
    burst(2);

    // pointer wrap (pointer is 0 after last grant to 2)
    tick();
    req = 3'b100;
    #1 chk("t6_gnt_a", 32'(gnt1), 3'b100);
    tick();
    req = 3'b011;
    #1 chk("t6_gnt_b", 32'(gnt1), 3'b001);
    tick();
    #1 chk("t6_gnt_c", 32'(gnt1), 3'b010);
    tick();
    req = 3'b000;
    tick();
    tick();

    // LAT=3 latency
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req = 3'b001; addr[0] = 16'h0A05;
    #1 chk("t5a_gnt3", 32'(gnt3), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      req = 3'b000;
      #1 chk("t5a_rvalid3", 32'(rvalid3), (k == 4) ? 1 : 0);
      if (k == 4) chk("t5a_rdata3", 32'(rdata3), 7);
    end

    // reset mid-flight, LAT=3
    tick();
    req = 3'b001;
    #1 chk("t5_gnt3", 32'(gnt3), 1);
    tick();
    req = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 3'b101;
    #1;
    chk("t5_gnt3_ptr", 32'(gnt3), 3'b001);
    chk("t5_gnt1_ptr", 32'(gnt1), 3'b001);
    tick();
    req = 3'b000;
    #1 chk("t5_flush_t4", 32'(rvalid3), 0);
    tick();
    #1 chk("t5_flush_t5", 32'(rvalid3), 0);
    tick();
    #1 chk("t5_flush_t6", 32'(rvalid3), 0);
    tick();
    #1;
    chk("t5_new_rvalid3", 32'(rvalid3), 1);
    chk("t5_new_rdata3", 32'(rdata3), 7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
